csa_accumulator: RTL

Parametrised, multi-beat carry-save accumulator with an optional per-beat subtract and a chunked carry-propagate resolve stage. Sits in front of the modular-reduction datapath of the cryptoprocessor and sums a stream of W-bit partial products in redundant (sum, carry) form at one beat per cycle. On the last beat it converts the redundant state to a binary result over ceil(ACC_W/CPA_CHUNK) cycles. This generalises the fixed 40-bit 3:2 compressor to configurable widths, adds sequential accumulation and an output handshake.

---
 rtl/csa_pkg.sv | 26 ++
 rtl/csa_accumulator_if.sv | 26 ++
 rtl/csa_row.sv | 21 ++
 rtl/csa_accumulator.sv | 113 +++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared types and sizing helpers for the carry-save accumulator.
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Number of carry-propagate chunks needed to cover acc_w bits.
  function automatic int nch(input int acc_w, input int chunk);
    return (acc_w + chunk - 1) / chunk;
  endfunction

  // Chunk-index counter width; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_ACC_W = 48;
  localparam int DEF_CHUNK = 16;
  localparam int DEF_NCH   = nch(DEF_ACC_W, DEF_CHUNK);
  localparam int DEF_IDX_W = idx_w(DEF_NCH);

endpackage

// File: rtl/csa_accumulator_if.sv
// Beat-input and result-output handshake bundle of the accumulator.
interface csa_accumulator_if #(
  parameter int W     = 40,
  parameter int ACC_W = 48,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_sub;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, in_sub, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count
  );

  modport slave (
    input  in_valid, in_data, in_sub, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count
  );
endinterface

// File: rtl/csa_row.sv
// N-bit 3:2 compressor. The carry vector is pre-shifted: bit 0 comes from
// cin_lsb and the majority out of the top bit is discarded (mod 2^N).
module csa_row #(
  parameter int N = 48
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] x,
  input  logic         cin_lsb,
  output logic [N-1:0] s,
  output logic [N-1:0] c
);
  logic [N-2:0] maj;

  // Bitwise sum and majority; only the lower N-1 majority bits survive the shift.
  always_comb begin
    s   = a ^ b ^ x;
    maj = (a[N-2:0] & b[N-2:0]) | (a[N-2:0] & x[N-2:0]) | (b[N-2:0] & x[N-2:0]);
    c   = {maj, cin_lsb};
  end
endmodule

// File: rtl/csa_accumulator.sv
// Multi-beat carry-save accumulator with per-beat subtract and a chunked
// carry-propagate resolve that runs one CPA_CHUNK slice per cycle.
module csa_accumulator
  import csa_pkg::*;
#(
  parameter int W         = 40,
  parameter int ACC_W     = 48,
  parameter int CPA_CHUNK = 16,
  parameter int CNT_W     = 16
) (
  input logic               clk,
  input logic               rst,
  csa_accumulator_if.slave  bus
);
  localparam int NCH   = nch(ACC_W, CPA_CHUNK);
  localparam int IDX_W = idx_w(NCH);
  localparam int PAD_W = NCH * CPA_CHUNK;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc_s, acc_c;
  logic [ACC_W-1:0] x, s_new, c_new;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] k;
  logic             cin;
  logic [PAD_W-1:0] res;
  logic [PAD_W-1:0] s_pad, c_pad;
  logic [CPA_CHUNK:0] chunk_sum;
  logic             accept;
  logic             last_chunk;

  // Beat counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign bus.in_ready  = !rst && (state == IDLE || state == ACCUM);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state == DONE);
  assign bus.out_sum   = res[ACC_W-1:0];
  assign bus.out_count = count;
  assign last_chunk    = (k == IDX_W'(NCH - 1));

  // Operand zero-extension; subtract inverts here and the +1 rides in c[0].
  always_comb begin
    x = '0;
    x[W-1:0] = bus.in_data;
    if (bus.in_sub) x = ~x;
  end

  csa_row #(.N(ACC_W)) u_row (
    .a       (acc_s),
    .b       (acc_c),
    .x       (x),
    .cin_lsb (bus.in_sub),
    .s       (s_new),
    .c       (c_new)
  );

  // Zero-pad the redundant state to whole chunks and add the current slice.
  always_comb begin
    s_pad = '0;
    c_pad = '0;
    s_pad[ACC_W-1:0] = acc_s;
    c_pad[ACC_W-1:0] = acc_c;
    chunk_sum = {1'b0, s_pad[int'(k)*CPA_CHUNK +: CPA_CHUNK]}
              + {1'b0, c_pad[int'(k)*CPA_CHUNK +: CPA_CHUNK]}
              + (CPA_CHUNK+1)'(cin);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = bus.in_last ? RESOLVE : ACCUM;
      ACCUM:   if (accept && bus.in_last) state_nxt = RESOLVE;
      RESOLVE: if (last_chunk) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator, beat counter and chunked carry-propagate registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_s <= '0;
      acc_c <= '0;
      count <= '0;
      k     <= '0;
      cin   <= 1'b0;
      res   <= '0;
    end else if (accept) begin
      acc_s <= s_new;
      acc_c <= c_new;
      count <= sat_inc(count);
      k     <= '0;
      cin   <= 1'b0;
    end else if (state == RESOLVE) begin
      res[int'(k)*CPA_CHUNK +: CPA_CHUNK] <= chunk_sum[CPA_CHUNK-1:0];
      cin <= chunk_sum[CPA_CHUNK];
      k   <= k + IDX_W'(1);
    end else if (state == DONE && bus.out_ready) begin
      acc_s <= '0;
      acc_c <= '0;
      count <= '0;
    end
  end
endmodule
